fetch_q_replayer: RTL

FETCH_Q_REPLAYER -- requirements
Module: fetch_q_replayer

---
 rtl/fetch_q_replayer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_q_replayer.sv
// fetch_q_replayer: replays a recorded fetch-queue trace into a queue under test.
// Each accepted trace word is driven onto q_rst/q_enqueue/q_dequeue one cycle later.
// In that same driven cycle the recorded full/empty status is compared with the live queue status.
// Build option: define FETCHQ_REPLAY_CHECK_EN to compile the status checker.
// Without it, the mismatch counter, first-mismatch index and error stay 0, and HALT is never entered.
module fetch_q_replayer #(
    parameter int CNT_W = 32,
    parameter int MIS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_on_mismatch,
    input  logic             trace_valid,
    input  logic [4:0]       trace_data,
    input  logic             trace_last,
    output logic             trace_ready,
    output logic             q_rst,
    output logic             q_enqueue,
    output logic             q_dequeue,
    input  logic             q_full,
    input  logic             q_empty,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] step_count,
    output logic [MIS_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_mismatch_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MIS_W-1:0] MIS_ONE = {{(MIS_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_drv_valid;   // a held word is being driven this cycle
    logic             r_q_rst;
    logic             r_q_enq;
    logic             r_q_deq;
    logic             r_exp_full;
    logic             r_exp_empty;
    logic [CNT_W-1:0] r_step_cnt;
    logic [MIS_W-1:0] r_mis_cnt;
    logic [CNT_W-1:0] r_first_idx;

    logic w_accept;
    logic w_mismatch;
    logic w_halt;

    assign trace_ready = (r_state == S_RUN);
    assign w_accept    = trace_valid && trace_ready;

`ifdef FETCHQ_REPLAY_CHECK_EN
    // Only driven cycles are compared; bubbles carry no expectation.
    assign w_mismatch = r_drv_valid &&
                        ({q_full, q_empty} != {r_exp_full, r_exp_empty});
`else
    assign w_mismatch = 1'b0;
    // Status inputs and held expectations have no consumer in this build.
    logic w_unused_status;
    assign w_unused_status = ^{q_full, q_empty, r_exp_full, r_exp_empty};
`endif

    assign w_halt = w_mismatch && halt_on_mismatch;

    // Replay state machine, held word, step and mismatch bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drv_valid <= 1'b0;
            r_q_rst     <= 1'b0;
            r_q_enq     <= 1'b0;
            r_q_deq     <= 1'b0;
            r_exp_full  <= 1'b0;
            r_exp_empty <= 1'b0;
            r_step_cnt  <= '0;
            r_mis_cnt   <= '0;
            r_first_idx <= '0;
        end else begin
            // A cycle without acceptance becomes a zero-drive bubble next cycle.
            r_drv_valid <= 1'b0;
            r_q_rst     <= 1'b0;
            r_q_enq     <= 1'b0;
            r_q_deq     <= 1'b0;

            if (r_drv_valid) begin
                if (r_step_cnt != '1) begin
                    r_step_cnt <= r_step_cnt + CNT_ONE;
                end
                if (w_mismatch) begin
                    // The index is the step count before this step is added.
                    if (r_mis_cnt == '0) begin
                        r_first_idx <= r_step_cnt;
                    end
                    if (r_mis_cnt != '1) begin
                        r_mis_cnt <= r_mis_cnt + MIS_ONE;
                    end
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_step_cnt  <= '0;
                        r_mis_cnt   <= '0;
                        r_first_idx <= '0;
                    end
                end
                S_RUN: begin
                    // Halting wins over loading a word accepted in the same cycle, even a last one.
                    if (w_halt) begin
                        r_state <= S_HALT;
                    end else if (w_accept) begin
                        r_drv_valid <= 1'b1;
                        r_q_rst     <= trace_data[4];
                        r_q_enq     <= trace_data[3];
                        r_q_deq     <= trace_data[2];
                        r_exp_full  <= trace_data[1];
                        r_exp_empty <= trace_data[0];
                        if (trace_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= w_halt ? S_HALT : S_DONE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign q_rst              = r_q_rst;
    assign q_enqueue          = r_q_enq;
    assign q_dequeue          = r_q_deq;
    assign busy               = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done               = (r_state == S_DONE);
    assign error              = (r_state == S_HALT) ||
                                ((r_state == S_DONE) && (r_mis_cnt != '0));
    assign step_count         = r_step_cnt;
    assign mismatch_count     = r_mis_cnt;
    assign first_mismatch_idx = r_first_idx;

endmodule
